multi_busyctr: RTL and testbench
================================

# multi_busyctr

Bank of NCH independent busy-interval timers, the parametrised successor to the single-channel busy counter. Each channel loads a programmable cycle count on a start request, asserts busy for exactly that many cycles, and then emits a one-cycle done pulse. Each channel also supports abort and missed-start flagging. It sits between request sources and shared resources that need a guaranteed hold-off window.

## Interface
- WIDTH, 16: counter and amount width in bits, 2..32.
- NCH, 4: number of channels, 1..16.
- DEFAULT_AMOUNT, 22: load value used when the requested amount is 0; must satisfy 1 <= DEFAULT_AMOUNT < 2^WIDTH.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  NCH  per-channel start request, level-sampled each cycle.
- i_amount  in  NCH*WIDTH  per-channel busy length; channel c occupies bits [c*WIDTH +: WIDTH].
- i_abort  in  NCH  per-channel abort; clears the counter without a done pulse.
- o_busy  out  NCH  channel c is high while its counter is nonzero (combinational from the counter register).
- o_done  out  NCH  registered one-cycle pulse marking natural expiry.
- o_missed  out  NCH  sticky flag: a start arrived while the channel was busy and was not honoured.
- o_any_busy  out  1  OR of o_busy.
- o_count  out  NCH*WIDTH  current counter value per channel, same packing as i_amount.

## Operation
- Per channel c, load value L = (i_amount[c] == 0) ? DEFAULT_AMOUNT : i_amount[c], truncated to WIDTH bits.
- Counter update priority, highest first:
  - reset: counter = 0.
  - abort: counter = 0.
  - accepted start: counter = L.
  - counter != 0: counter = counter - 1.
  - otherwise: hold.
- A start is accepted when counter == 0. With BUSYCTR_RETRIG_EN it is also accepted when counter != 0.
- A start with counter != 0 that is not accepted sets o_missed[c]. o_missed clears only on reset.
- o_done[c] is set on the edge where the counter goes from 1 to 0 by decrement. It is cleared on every other edge.
- No done pulse when the counter is zeroed by abort or reset, or when it is reloaded by a retrigger in its counter==1 cycle.
- Channels are fully independent; there is no arbitration between them.
- Arithmetic is unsigned modulo 2^WIDTH. The counter never decrements below 0 and never wraps.

## Timing
- Reset values: every counter = 0, o_busy = 0, o_done = 0, o_missed = 0, o_any_busy = 0, o_count = 0.
- A start accepted at edge t makes o_busy high from cycle t+1 through t+L inclusive, i.e. exactly L cycles.
- o_done is high in cycle t+L+1 only.
- A new start accepted at edge t+L (counter == 0 in cycle t+L... not applicable) is not possible; the earliest back-to-back start is sampled in cycle t+L+1, when counter == 0. That gives one idle cycle between intervals, the cycle in which o_done is high.
- Abort sampled in cycle k forces o_busy low from cycle k+1.
- Start together with abort in the same cycle: abort wins, counter = 0, o_missed unchanged.
- Reset mid-interval: all outputs return to their reset values at the next cycle, including o_missed.
- i_amount is sampled only on the cycle of an accepted start. Later changes do not affect a running interval.

## Configuration
- BUSYCTR_RETRIG_EN defined:
  - A start while busy reloads the counter with L, extending or shortening the interval.
  - o_missed is tied to 0.
  - A retrigger in the counter==1 cycle suppresses o_done.
- BUSYCTR_RETRIG_EN undefined:
  - A start while busy is ignored and sets o_missed.
  - The running interval is unaffected.

## Test plan
- Reset release, NCH=4, WIDTH=16: o_busy=0, o_done=0, o_missed=0, o_count all 0 for 5 idle cycles.
- ch0 start with amount=5: o_busy[0] high exactly 5 cycles; o_count[0] reads 5,4,3,2,1; o_done[0] high one cycle after; other channels stay idle.
- ch1 start with amount=0: o_busy[1] high exactly 22 cycles (DEFAULT_AMOUNT), then o_done[1].
- ch2 start with amount=10, then start with amount=3 at count 4:
  - Macro undefined: busy ends on the original schedule and o_missed[2]=1 until reset.
  - Macro defined: count reloads to 3, busy lasts 3 more cycles, o_missed[2]=0.
- ch3 start with amount=8, abort at count 5: o_busy[3] low next cycle, no o_done[3]. Then start+abort in the same cycle: counter stays 0.
- All channels started with amount=1: o_busy all high one cycle, o_any_busy high one cycle, o_done all high the following cycle. Apply reset mid-interval on a second run: all outputs are 0 at the next cycle.

Source files
------------

// File: rtl/multi_busyctr.sv
// Bank of NCH independent busy-interval timers with done pulse and missed-start flag.
// Optional macro BUSYCTR_RETRIG_EN: a start while busy reloads the counter.
module multi_busyctr #(
  parameter int WIDTH          = 16,
  parameter int NCH            = 4,
  parameter int DEFAULT_AMOUNT = 22
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NCH-1:0]     i_start,
  input  logic [NCH*WIDTH-1:0] i_amount,
  input  logic [NCH-1:0]     i_abort,
  output logic [NCH-1:0]     o_busy,
  output logic [NCH-1:0]     o_done,
  output logic [NCH-1:0]     o_missed,
  output logic               o_any_busy,
  output logic [NCH*WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_AMOUNT);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] amt;
    logic [WIDTH-1:0] load;
    logic             busy;
    logic             take;

    assign amt  = i_amount[c*WIDTH +: WIDTH];
    assign load = (amt == '0) ? DEF : amt;
    assign busy = (cnt != '0);
`ifdef BUSYCTR_RETRIG_EN
    assign take = i_start[c];
`else
    assign take = i_start[c] & ~busy;
`endif

    // counter and done pulse: abort > start > decrement > hold
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        cnt       <= '0;
        o_done[c] <= 1'b0;
      end else begin
        o_done[c] <= 1'b0;
        if (i_abort[c]) begin
          cnt <= '0;
        end else if (take) begin
          cnt <= load;
        end else if (busy) begin
          cnt <= cnt - 1'b1;
          if (cnt == WIDTH'(1)) o_done[c] <= 1'b1;
        end
      end
    end

`ifdef BUSYCTR_RETRIG_EN
    assign o_missed[c] = 1'b0;
`else
    logic missed;
    // sticky flag for a start refused because the channel was busy
    always_ff @(posedge i_clk) begin
      if (i_reset)
        missed <= 1'b0;
      else if (i_start[c] & ~i_abort[c] & busy)
        missed <= 1'b1;
    end
    assign o_missed[c] = missed;
`endif

    assign o_busy[c]                  = busy;
    assign o_count[c*WIDTH +: WIDTH]  = cnt;
  end

  assign o_any_busy = |o_busy;

endmodule

// File: tb/tb_multi_busyctr.sv
// Directed bench for multi_busyctr (NCH=4, WIDTH=16, DEFAULT_AMOUNT=22).
// Expectations follow BUSYCTR_RETRIG_EN where channel 2 differs.
module tb_multi_busyctr;
  localparam int W = 16;
  localparam int N = 4;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic [N-1:0]   i_start;
  logic [N*W-1:0] i_amount;
  logic [N-1:0]   i_abort;
  logic [N-1:0]   o_busy;
  logic [N-1:0]   o_done;
  logic [N-1:0]   o_missed;
  logic           o_any_busy;
  logic [N*W-1:0] o_count;

  int errors = 0;
  int checks = 0;

  multi_busyctr #(.WIDTH(W), .NCH(N), .DEFAULT_AMOUNT(22)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_amount(i_amount), .i_abort(i_abort), .o_busy(o_busy),
    .o_done(o_done), .o_missed(o_missed), .o_any_busy(o_any_busy),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

`ifdef BUSYCTR_RETRIG_EN
  localparam logic [N-1:0] MISS2 = 4'b0000;
`else
  localparam logic [N-1:0] MISS2 = 4'b0100;
`endif

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int c);
    return o_count[c*W +: W];
  endfunction

  task automatic set_amt(input int c, input logic [W-1:0] v);
    i_amount[c*W +: W] = v;
  endtask

  initial begin
    i_reset  = 1'b1;
    i_start  = '0;
    i_abort  = '0;
    i_amount = '0;
    tick();
    tick();
    i_reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_busy", 64'(o_busy), 0);
      chk("rst_done", 64'(o_done), 0);
      chk("rst_missed", 64'(o_missed), 0);
      chk("rst_any", 64'(o_any_busy), 0);
      chk("rst_count", o_count, 0);
    end

    // ch0, amount 5
    set_amt(0, 16'd5);
    i_start = 4'b0001;
    tick();
    i_start = '0;
    set_amt(0, 16'd9);
    for (int k = 5; k >= 1; k--) begin
      chk("c0_count", 64'(cnt(0)), 64'(k));
      chk("c0_busy", 64'(o_busy), 64'b0001);
      chk("c0_done_lo", 64'(o_done), 0);
      tick();
    end
    chk("c0_end_busy", 64'(o_busy), 0);
    chk("c0_done", 64'(o_done), 64'b0001);
    tick();
    chk("c0_done_clr", 64'(o_done), 0);

    // ch1, amount 0 -> default 22
    set_amt(1, 16'd0);
    i_start = 4'b0010;
    tick();
    i_start = '0;
    for (int k = 22; k >= 1; k--) begin
      chk("c1_count", 64'(cnt(1)), 64'(k));
      chk("c1_busy", 64'(o_busy), 64'b0010);
      tick();
    end
    chk("c1_end_busy", 64'(o_busy), 0);
    chk("c1_done", 64'(o_done), 64'b0010);

    // ch2, amount 10 then start(3) at count 4
    set_amt(2, 16'd10);
    i_start = 4'b0100;
    tick();
    i_start = '0;
    chk("c2_load", 64'(cnt(2)), 10);
    for (int i = 0; i < 6; i++) tick();
    chk("c2_at4", 64'(cnt(2)), 4);
    set_amt(2, 16'd3);
    i_start = 4'b0100;
    tick();
    i_start = '0;
    // both builds reach 3 here: decrement 4->3, or reload to 3
    for (int k = 3; k >= 1; k--) begin
      chk("c2_count", 64'(cnt(2)), 64'(k));
      chk("c2_busy", 64'(o_busy), 64'b0100);
      chk("c2_missed", 64'(o_missed), 64'(MISS2));
      tick();
    end
    chk("c2_end_busy", 64'(o_busy), 0);
    chk("c2_done", 64'(o_done), 64'b0100);
    tick();
    chk("c2_missed_sticky", 64'(o_missed), 64'(MISS2));

    // ch3, amount 8, abort at count 5
    set_amt(3, 16'd8);
    i_start = 4'b1000;
    tick();
    i_start = '0;
    chk("c3_load", 64'(cnt(3)), 8);
    tick(); tick(); tick();
    chk("c3_at5", 64'(cnt(3)), 5);
    i_abort = 4'b1000;
    tick();
    i_abort = '0;
    chk("c3_abort_busy", 64'(o_busy), 0);
    chk("c3_abort_cnt", 64'(cnt(3)), 0);
    chk("c3_abort_done", 64'(o_done), 0);
    tick();
    chk("c3_abort_done2", 64'(o_done), 0);
    i_start = 4'b1000;
    i_abort = 4'b1000;
    tick();
    i_start = '0;
    i_abort = '0;
    chk("c3_sa_cnt", 64'(cnt(3)), 0);
    chk("c3_sa_busy", 64'(o_busy), 0);
    chk("c3_sa_missed", 64'(o_missed), 64'(MISS2));
    tick();
    chk("c3_sa_done", 64'(o_done), 0);

    // all channels, amount 1
    for (int c = 0; c < N; c++) set_amt(c, 16'd1);
    i_start = 4'b1111;
    tick();
    i_start = '0;
    chk("all_busy", 64'(o_busy), 64'hF);
    chk("all_any", 64'(o_any_busy), 1);
    chk("all_count", o_count, 64'h0001_0001_0001_0001);
    tick();
    chk("all_busy_off", 64'(o_busy), 0);
    chk("all_any_off", 64'(o_any_busy), 0);
    chk("all_done", 64'(o_done), 64'hF);
    tick();
    chk("all_done_clr", 64'(o_done), 0);

    // second run, reset mid-interval
    for (int c = 0; c < N; c++) set_amt(c, 16'd6);
    i_start = 4'b1111;
    tick();
    i_start = '0;
    chk("r2_busy", 64'(o_busy), 64'hF);
    chk("r2_missed_pre", 64'(o_missed), 64'(MISS2));
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("r2_busy_rst", 64'(o_busy), 0);
    chk("r2_done_rst", 64'(o_done), 0);
    chk("r2_missed_rst", 64'(o_missed), 0);
    chk("r2_any_rst", 64'(o_any_busy), 0);
    chk("r2_count_rst", o_count, 0);
    tick();
    chk("r2_done_after", 64'(o_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
